// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array operand scheduler.
//   sa_state_e   : scheduler FSM states
//   SA_N         : default array dimension
//   DRAIN_CYC    : drain length for the default array dimension (2*N)
//   drain_cycles : drain length for an arbitrary array dimension
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } sa_state_e;

  localparam int SA_N      = 8;
  localparam int DRAIN_CYC = 2 * SA_N;

  // Last operand enters at the array corner, then needs up to 2N hops to
  // reach the far accumulator.
  function automatic int drain_cycles(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/sa_sched_if.sv
// Control/operand-feed bundle between the scheduler and its environment.
//   I_START, I_K_LEN, I_STALL : job request and upstream readiness
//   O_BUSY, O_DONE            : job status
//   O_PE_SRSTN                : active-low synchronous accumulator clear
//   O_RD_EN, O_RD_ADDR        : operand buffer read port (1-cycle latency)
//   O_ROW_VLD, O_COL_VLD      : skewed left/top-edge valids into the array
interface sa_sched_if #(
  parameter int N   = 8,
  parameter int K_W = 8
);
  logic           I_START;
  logic [K_W-1:0] I_K_LEN;
  logic           I_STALL;
  logic           O_BUSY;
  logic           O_PE_SRSTN;
  logic           O_RD_EN;
  logic [K_W-1:0] O_RD_ADDR;
  logic [N-1:0]   O_ROW_VLD;
  logic [N-1:0]   O_COL_VLD;
  logic           O_DONE;

  modport master (
    output I_START, I_K_LEN, I_STALL,
    input  O_BUSY, O_PE_SRSTN, O_RD_EN, O_RD_ADDR, O_ROW_VLD, O_COL_VLD, O_DONE
  );

  modport slave (
    input  I_START, I_K_LEN, I_STALL,
    output O_BUSY, O_PE_SRSTN, O_RD_EN, O_RD_ADDR, O_ROW_VLD, O_COL_VLD, O_DONE
  );
endinterface

// File: rtl/sa_sched_skew_pipe.sv
// N-stage valid delay line: dout[i] is din delayed by 1+i cycles.
//   I_CLK, I_ASYN_RST : clock, async active-high reset
//   clr               : synchronous flush of every stage
//   din               : read-enable stream
//   dout              : per-row/column skewed valids
module skew_pipe #(
  parameter int N = 8
) (
  input  logic         I_CLK,
  input  logic         I_ASYN_RST,
  input  logic         clr,
  input  logic         din,
  output logic [N-1:0] dout
);

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      dout <= '0;
    end else if (clr) begin
      dout <= '0;
    end else begin
      dout <= (dout << 1) | N'(din);
    end
  end

endmodule

// File: rtl/sa_sched.sv
// Operand-feed scheduler for an N x N systolic array.
//   I_CLK, I_ASYN_RST : clock, async active-high reset
//   bus (slave)       : start/K/stall in; busy, PE clear, buffer read port,
//                       skewed row/column valids and done pulse out
// Every output is a register loaded from the state the FSM is in at that
// edge, so an output reflecting state S appears the cycle after S is entered.
module sa_sched
  import sa_pkg::*;
#(
  parameter int N   = 8,
  parameter int K_W = 8
) (
  input  logic I_CLK,
  input  logic I_ASYN_RST,
  sa_sched_if.slave bus
);

  localparam int DRAIN_N = drain_cycles(N);
  localparam int DCW     = $clog2(DRAIN_N);

  sa_state_e      state;
  logic [K_W-1:0] k;
  logic [K_W-1:0] k_len;
  logic [DCW-1:0] drain_cnt;

  logic           busy_q;
  logic           pe_srstn_q;
  logic           rd_en_q;
  logic [K_W-1:0] rd_addr_q;
  logic           done_q;
  logic [N-1:0]   vld;
  logic           skew_clr;

  always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
    if (I_ASYN_RST) begin
      state      <= ST_IDLE;
      k          <= '0;
      k_len      <= '0;
      drain_cnt  <= '0;
      busy_q     <= 1'b0;
      pe_srstn_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      busy_q     <= (state != ST_IDLE);
      pe_srstn_q <= (state != ST_CLEAR);
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.I_START && (bus.I_K_LEN != '0)) begin
            k_len <= bus.I_K_LEN;
            k     <= '0;
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          state <= ST_FEED;
        end
        ST_FEED: begin
          if (!bus.I_STALL) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= k;
            // Stop on the last index instead of incrementing past it, so
            // K = 2^K_W-1 never wraps the counter.
            if (k == k_len - K_W'(1)) begin
              drain_cnt <= '0;
              state     <= ST_DRAIN;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DCW'(DRAIN_N - 1)) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + DCW'(1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign skew_clr = (state == ST_IDLE) || (state == ST_CLEAR);

  skew_pipe #(.N(N)) u_skew (
    .I_CLK      (I_CLK),
    .I_ASYN_RST (I_ASYN_RST),
    .clr        (skew_clr),
    .din        (rd_en_q),
    .dout       (vld)
  );

  assign bus.O_BUSY     = busy_q;
  assign bus.O_PE_SRSTN = pe_srstn_q;
  assign bus.O_RD_EN    = rd_en_q;
  assign bus.O_RD_ADDR  = rd_addr_q;
  assign bus.O_DONE     = done_q;
  assign bus.O_ROW_VLD  = vld;
  assign bus.O_COL_VLD  = vld;

endmodule

// File: tb/tb_sa_sched.sv
// Self-checking bench for sa_sched (N=4, K_W=8). Each segment starts with a
// reset; cycle t is the value seen just after the t-th rising edge following
// reset release. Expected traces come from a job-level model of the rules.
module tb_sa_sched;

  localparam int N    = 4;
  localparam int K_W  = 8;
  localparam int MAXT = 600;

  logic I_CLK = 1'b0;
  logic I_ASYN_RST = 1'b1;

  sa_sched_if #(.N(N), .K_W(K_W)) bus ();

  sa_sched #(.N(N), .K_W(K_W)) dut (
    .I_CLK      (I_CLK),
    .I_ASYN_RST (I_ASYN_RST),
    .bus        (bus)
  );

  always #5 I_CLK = ~I_CLK;

  // Stimulus per cycle
  bit             st_start [MAXT];
  logic [K_W-1:0] st_klen  [MAXT];
  bit             st_stall [MAXT];

  // Expected per cycle
  bit             ex_busy  [MAXT];
  bit             ex_srstn [MAXT];
  bit             ex_rd    [MAXT];
  int             ex_addr  [MAXT];
  bit             ex_done  [MAXT];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int t = 0; t < MAXT; t++) begin
      st_start[t] = 1'b0;
      st_klen[t]  = '0;
      st_stall[t] = 1'b0;
    end
  endtask

  function automatic bit stall_at(input int u);
    return (u < MAXT) ? st_stall[u] : 1'b0;
  endfunction

  // Job-level model: accepted starts, the cycles where reads land, and the
  // done cycle 2N+1 after the last read.
  task automatic build_model(input int len);
    int free_t;
    free_t = 0;
    for (int t = 0; t < MAXT; t++) begin
      ex_busy[t] = 1'b0; ex_srstn[t] = 1'b1; ex_rd[t] = 1'b0;
      ex_addr[t] = 0;    ex_done[t]  = 1'b0;
    end
    for (int t = 0; t < len; t++) begin
      if (st_start[t] && st_klen[t] != 0 && t >= free_t) begin
        int kk, n, u, last, done_t;
        kk = int'(st_klen[t]);
        n = 0; u = t + 2; last = u;
        if (t + 1 < MAXT) ex_srstn[t + 1] = 1'b0;
        while (n < kk) begin
          if (!stall_at(u)) begin
            if (u < MAXT) begin ex_rd[u] = 1'b1; ex_addr[u] = n; end
            last = u;
            n++;
          end
          u++;
        end
        done_t = last + 2 * N + 1;
        for (int b = t + 1; b <= done_t && b < MAXT; b++) ex_busy[b] = 1'b1;
        if (done_t < MAXT) ex_done[done_t] = 1'b1;
        free_t = done_t + 1;
      end
    end
  endtask

  function automatic logic [N-1:0] exp_vld(input int t);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - 1 - i >= 0) v[i] = ex_rd[t - 1 - i];
    return v;
  endfunction

  task automatic run_seg(input string name, input int len);
    int dut_dones, exp_dones;
    build_model(len);
    dut_dones = 0;
    exp_dones = 0;
    I_ASYN_RST = 1'b1;
    #1;
    chk({name, " rst busy"},  32'(bus.O_BUSY), 0);
    chk({name, " rst srstn"}, 32'(bus.O_PE_SRSTN), 0);
    chk({name, " rst rd_en"}, 32'(bus.O_RD_EN), 0);
    chk({name, " rst addr"},  32'(bus.O_RD_ADDR), 0);
    chk({name, " rst row"},   32'(bus.O_ROW_VLD), 0);
    chk({name, " rst col"},   32'(bus.O_COL_VLD), 0);
    chk({name, " rst done"},  32'(bus.O_DONE), 0);
    @(negedge I_CLK);
    I_ASYN_RST = 1'b0;
    for (int t = 0; t < len; t++) begin
      string c;
      if (t > 0) @(negedge I_CLK);
      bus.I_START = st_start[t];
      bus.I_K_LEN = st_klen[t];
      bus.I_STALL = st_stall[t];
      @(posedge I_CLK);
      #1;
      c = $sformatf("%s c%0d", name, t);
      chk({c, " busy"},  32'(bus.O_BUSY), 32'(ex_busy[t]));
      chk({c, " srstn"}, 32'(bus.O_PE_SRSTN), 32'(ex_srstn[t]));
      chk({c, " rd_en"}, 32'(bus.O_RD_EN), 32'(ex_rd[t]));
      if (ex_rd[t]) chk({c, " addr"}, 32'(bus.O_RD_ADDR), 32'(ex_addr[t]));
      chk({c, " row"},   32'(bus.O_ROW_VLD), 32'(exp_vld(t)));
      chk({c, " col"},   32'(bus.O_COL_VLD), 32'(exp_vld(t)));
      chk({c, " done"},  32'(bus.O_DONE), 32'(ex_done[t]));
      if (bus.O_DONE === 1'b1) dut_dones++;
      if (ex_done[t]) exp_dones++;
    end
    chk({name, " done_count"}, 32'(dut_dones), 32'(exp_dones));
    bus.I_START = 1'b0;
    bus.I_STALL = 1'b0;
    bus.I_K_LEN = '0;
  endtask

  initial begin
    bus.I_START = 1'b0;
    bus.I_K_LEN = '0;
    bus.I_STALL = 1'b0;
    #12;

    // K=3, no stall, with ignored start pulses at cycles 5 and 13
    clear_stim();
    st_start[0] = 1; st_klen[0] = 8'd3;
    st_start[5] = 1; st_klen[5] = 8'd3;
    st_start[13] = 1; st_klen[13] = 8'd3;
    run_seg("k3", 20);

    // K=3 with one stall bubble at cycle 3
    clear_stim();
    st_start[0] = 1; st_klen[0] = 8'd3;
    st_stall[3] = 1;
    run_seg("k3stall", 20);

    // Start with K=0 must be ignored
    clear_stim();
    for (int t = 0; t < 6; t++) begin st_start[t] = 1; st_klen[t] = '0; end
    run_seg("k0", 12);

    // K=3 job cut short by reset after cycle 3, then an idle segment
    clear_stim();
    st_start[0] = 1; st_klen[0] = 8'd3;
    run_seg("midrst", 4);
    clear_stim();
    run_seg("postrst", 16);

    // Back-to-back: start in DONE cycle ignored, next IDLE cycle accepted
    clear_stim();
    st_start[0] = 1; st_klen[0] = 8'd1;
    st_start[11] = 1; st_klen[11] = 8'd2;
    st_start[12] = 1; st_klen[12] = 8'd2;
    run_seg("b2b", 30);

    // Maximum K with no wrap
    clear_stim();
    st_start[0] = 1; st_klen[0] = 8'd255;
    run_seg("kmax", 275);

    // Randomised jobs, stalls and start requests
    for (int s = 0; s < 6; s++) begin
      clear_stim();
      for (int t = 0; t < MAXT; t++) begin
        st_stall[t] = ($urandom_range(0, 2) == 0);
        st_start[t] = ($urandom_range(0, 5) == 0);
        st_klen[t]  = K_W'($urandom_range(0, 12));
      end
      run_seg($sformatf("rnd%0d", s), 90);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sa_sched.md
SA_SCHED -- requirements
Module: sa_sched

Interface
REQ-001 Parameter N, default 8, meaning systolic array dimension (N x N PEs).
REQ-002 Parameter K_W, default 8, meaning width of the inner-dimension length and read address.
REQ-003 I_CLK  input  1  sole clock, rising edge.
REQ-004 I_ASYN_RST  input  1  reset, asynchronous assert, active-high.
REQ-005 I_START  input  1  start request, sampled only in IDLE.
REQ-006 I_K_LEN  input  K_W  inner-dimension length K, sampled with an accepted I_START.
REQ-007 I_STALL  input  1  upstream operand buffers not ready; pauses feeding.
REQ-008 O_BUSY  output  1  high in every state except IDLE.
REQ-009 O_PE_SRSTN  output  1  active-low synchronous clear to all PE accumulators.
REQ-010 O_RD_EN  output  1  operand buffer read enable; buffers have 1-cycle read latency.
REQ-011 O_RD_ADDR  output  K_W  k index being read.
REQ-012 O_ROW_VLD  output  N  bit i = PE-row-i left-edge valid.
REQ-013 O_COL_VLD  output  N  bit j = PE-column-j top-edge valid.
REQ-014 O_DONE  output  1  one-cycle pulse; all N x N accumulators hold final results.

Function
REQ-015 The FSM SHALL have the states IDLE, CLEAR, FEED, DRAIN and DONE, with all outputs registered.
REQ-016 IDLE -> CLEAR SHALL occur on I_START=1 with I_K_LEN!=0; K is latched at this point; I_START with I_K_LEN=0 SHALL be ignored.
REQ-017 CLEAR SHALL last exactly one cycle, with O_PE_SRSTN=0; O_PE_SRSTN SHALL be 1 in every other state.
REQ-018 In FEED, each cycle with I_STALL=0 SHALL drive O_RD_EN=1 and O_RD_ADDR=k, then increment k, with k starting at 0.
REQ-019 In FEED, each cycle with I_STALL=1 SHALL drive O_RD_EN=0 and hold k.
REQ-020 FEED -> DRAIN SHALL occur after the read with k=K-1 is issued; exactly K reads are issued per job.
REQ-021 O_ROW_VLD[i] and O_COL_VLD[i] SHALL each equal O_RD_EN delayed by 1+i cycles (read latency plus skew), with stall bubbles propagating as zeros.
REQ-022 DRAIN SHALL count 2N cycles from the cycle after the last O_RD_EN, ignore I_STALL, and then go to DONE.
REQ-023 DONE SHALL last one cycle with O_DONE=1 and then return to IDLE; a new I_START is accepted from the IDLE cycle onward.
REQ-024 I_START while O_BUSY=1 SHALL be ignored, without queuing.
REQ-025 The k counter SHALL be K_W bits wide; K=2^K_W-1 is the maximum, and no wrap-around occurs within a job.
REQ-026 The skew line SHALL be all-zero in IDLE and CLEAR, so no stale valid reaches the PEs.

Reset
REQ-027 While I_ASYN_RST=1, the block SHALL be in IDLE with O_BUSY=0, O_PE_SRSTN=0, O_RD_EN=0, O_RD_ADDR=0, O_ROW_VLD=0, O_COL_VLD=0, O_DONE=0, k=0 and the skew line cleared.
REQ-028 O_PE_SRSTN SHALL rise to 1 on the first clock edge after reset deassertion.
REQ-029 Reset mid-job SHALL abandon the job immediately, with no O_DONE.

Structure
REQ-030 The state enum typedef and the constant DRAIN_CYC=2*N SHALL live in the shared package sa_pkg.
REQ-031 The 1..N-stage valid delay line SHALL be the sub-module skew_pipe, parameterised by N, and instantiated once with its outputs fanned to both O_ROW_VLD and O_COL_VLD.

Verification (N=4; cycle 0 = edge that accepts I_START)
REQ-032 Case K=3, no stall: O_PE_SRSTN=0 at cycle 1; O_RD_EN=1 at cycles 2-4 with addr 0,1,2; O_ROW_VLD[3] high at cycles 6-8; O_DONE at cycle 13 only.
REQ-033 Case K=3, I_STALL=1 at cycle 3: addr 0 at cycle 2, bubble at cycle 3, addr 1,2 at cycles 4-5; O_ROW_VLD[0] = 1,0,1,1 at cycles 3-6; O_DONE at cycle 14.
REQ-034 Case I_K_LEN=0 with I_START=1: the block stays in IDLE, with O_BUSY=0 and no O_RD_EN.
REQ-035 Case I_START pulsed at cycles 5 and 13 of a K=3 job: both are ignored, and exactly one O_DONE is produced.
REQ-036 Case I_ASYN_RST asserted at cycle 3 of a K=3 job: all outputs are at reset values immediately, O_PE_SRSTN=1 after release, and there is no O_DONE.
REQ-037 Case K=255 with K_W=8: addr runs 0..254 without wrap, and O_DONE occurs exactly 2N+1 cycles after the last O_RD_EN.
